// File: rtl/irq_source_gen_if.sv
// Configuration, event/ack strobes and status outputs of the interrupt
// source generator, grouped as one bundle between driver and generator.
interface irq_source_gen_if #(
  parameter int CNT_W   = 8,
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 4
);
  logic               en;
  logic               mode;
  logic [PULSE_W-1:0] pulse_len;
  logic [GAP_W-1:0]   gap_len;
  logic               evt;
  logic               ack;
  logic               ovf_clr;
  logic               irq_out;
  logic               busy;
  logic [CNT_W-1:0]   pend_cnt;
  logic               overflow;

  modport master (
    output en, mode, pulse_len, gap_len, evt, ack, ovf_clr,
    input  irq_out, busy, pend_cnt, overflow
  );

  modport slave (
    input  en, mode, pulse_len, gap_len, evt, ack, ovf_clr,
    output irq_out, busy, pend_cnt, overflow
  );
endinterface

// File: rtl/irq_source_gen.sv
// Interrupt source generator: turns single-cycle event strobes into level
// (held until ack) or pulse (programmable width) interrupts, queues events
// in a saturating counter and enforces a minimum low gap between assertions.
module irq_source_gen #(
  parameter int CNT_W   = 8,
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 4
) (
  input  logic           pclk,
  input  logic           preset,
  irq_source_gen_if.slave bus
);

  localparam int TW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic             mode_q, mode_nxt;
  logic             irq_q, irq_nxt;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             ovf_q, ovf_nxt;
  logic             issue;

  // Next-state, waveform timer and issue decision
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    mode_nxt  = mode_q;
    irq_nxt   = irq_q;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && (cnt_q != '0)) begin
          issue     = 1'b1;
          state_nxt = ASSERT;
          irq_nxt   = 1'b1;
          mode_nxt  = bus.mode;
          // Timer holds remaining high cycles minus one; pulse_len 0 acts as 1
          timer_nxt = (bus.pulse_len == '0) ? '0 : (TW'(bus.pulse_len) - TW'(1));
        end
      end
      ASSERT: begin
        if ((mode_q && (timer == '0)) || (!mode_q && bus.ack)) begin
          state_nxt = GAP;
          irq_nxt   = 1'b0;
          timer_nxt = TW'(bus.gap_len);
        end else if (mode_q) begin
          timer_nxt = timer - TW'(1);
        end
      end
      GAP: begin
        if (timer == '0) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        irq_nxt   = 1'b0;
      end
    endcase
  end

  // Pending-event counter and sticky overflow
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (bus.ovf_clr) begin
      ovf_nxt = 1'b0;
    end
    if (bus.evt && !issue) begin
      if (cnt_q == '1) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end else if (!bus.evt && issue) begin
      cnt_nxt = cnt_q - CNT_W'(1);
    end
  end

  // State, latched config and output registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state  <= IDLE;
      timer  <= '0;
      mode_q <= 1'b0;
      irq_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      mode_q <= mode_nxt;
      irq_q  <= irq_nxt;
      busy_q <= (state_nxt != IDLE);
      cnt_q  <= cnt_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  assign bus.irq_out  = irq_q;
  assign bus.busy     = busy_q;
  assign bus.pend_cnt = cnt_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_irq_source_gen.sv
// Directed bench for irq_source_gen (counter width 2 so saturation is reachable).
module tb_irq_source_gen;

  localparam int CNT_W   = 2;
  localparam int PULSE_W = 4;
  localparam int GAP_W   = 4;

  logic pclk;
  logic preset;
  int   passed;
  int   total;

  irq_source_gen_if #(.CNT_W(CNT_W), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) bus ();

  irq_source_gen #(.CNT_W(CNT_W), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Step i: drive evt/ack bit i, clock once, then check irq_out/busy bit i
  task automatic run(input string tag, input int n, input logic [31:0] ev,
                     input logic [31:0] ak, input logic [31:0] iv, input logic [31:0] bv);
    for (int i = 0; i < n; i++) begin
      bus.evt = ev[i];
      bus.ack = ak[i];
      tick();
      chk($sformatf("%s.irq[%0d]", tag, i), 32'(bus.irq_out), 32'(iv[i]));
      chk($sformatf("%s.busy[%0d]", tag, i), 32'(bus.busy), 32'(bv[i]));
    end
    bus.evt = 1'b0;
    bus.ack = 1'b0;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    preset        = 1'b1;
    bus.en        = 1'b0;
    bus.mode      = 1'b0;
    bus.pulse_len = '0;
    bus.gap_len   = '0;
    bus.evt       = 1'b0;
    bus.ack       = 1'b0;
    bus.ovf_clr   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst.irq",  32'(bus.irq_out),  32'd0);
    chk("rst.busy", 32'(bus.busy),     32'd0);
    chk("rst.pend", 32'(bus.pend_cnt), 32'd0);
    chk("rst.ovf",  32'(bus.overflow), 32'd0);
    preset = 1'b0;

    // Pulse single: pulse_len=3, gap_len=2
    bus.en = 1'b1; bus.mode = 1'b1; bus.pulse_len = 4'd3; bus.gap_len = 4'd2;
    bus.evt = 1'b1;
    tick();
    bus.evt = 1'b0;
    chk("single.pend1", 32'(bus.pend_cnt), 32'd1);
    chk("single.irq0",  32'(bus.irq_out),  32'd0);
    run("single", 8, 32'h0, 32'h0, 32'h07, 32'h3F);
    chk("single.pend0", 32'(bus.pend_cnt), 32'd0);

    // Pulse burst: 4 strobes, pulse_len=1, gap_len=0
    bus.pulse_len = 4'd1; bus.gap_len = 4'd0;
    run("burst_a", 4, 32'hF, 32'h0, 32'h2, 32'h6);
    chk("burst.peak", 32'(bus.pend_cnt), 32'd3);
    run("burst_b", 10, 32'h0, 32'h0, 32'h49, 32'hDB);
    chk("burst.pend0", 32'(bus.pend_cnt), 32'd0);
    chk("burst.ovf",   32'(bus.overflow), 32'd0);

    // Level/ack: early ack in IDLE, ack 10 cycles after rise, ack in GAP ignored
    bus.mode = 1'b0; bus.gap_len = 4'd1;
    run("level", 16, 32'h2, 32'h3001, 32'hFFC, 32'h3FFC);
    chk("level.pend0", 32'(bus.pend_cnt), 32'd0);

    // Overflow: en=0, 5 strobes, max count 3
    bus.en = 1'b0; bus.mode = 1'b1; bus.pulse_len = 4'd1; bus.gap_len = 4'd0;
    run("ovf_fill", 5, 32'h1F, 32'h0, 32'h0, 32'h0);
    chk("ovf.pend3", 32'(bus.pend_cnt), 32'd3);
    chk("ovf.set",   32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    run("ovf_clr_drop", 1, 32'h1, 32'h0, 32'h0, 32'h0);
    chk("ovf.set_wins", 32'(bus.overflow), 32'd1);
    chk("ovf.pend_sat", 32'(bus.pend_cnt), 32'd3);
    run("ovf_clr", 1, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.ovf_clr = 1'b0;
    chk("ovf.clr", 32'(bus.overflow), 32'd0);
    bus.en = 1'b1;
    run("ovf_drain", 10, 32'h0, 32'h0, 32'h49, 32'hDB);
    chk("ovf.pend0", 32'(bus.pend_cnt), 32'd0);

    // Simultaneous evt and issue with pend_cnt=1
    bus.en = 1'b0;
    run("sim_load", 1, 32'h1, 32'h0, 32'h0, 32'h0);
    chk("sim.pend1", 32'(bus.pend_cnt), 32'd1);
    bus.en = 1'b1;
    run("sim_issue", 1, 32'h1, 32'h0, 32'h1, 32'h1);
    chk("sim.pend_hold", 32'(bus.pend_cnt), 32'd1);
    run("sim_drain", 6, 32'h0, 32'h0, 32'h04, 32'h0D);
    chk("sim.pend0", 32'(bus.pend_cnt), 32'd0);

    // Reset in the middle of a level assertion with two events queued
    bus.mode = 1'b0;
    run("rst_fill", 3, 32'h7, 32'h0, 32'h6, 32'h6);
    chk("rst_mid.pend2", 32'(bus.pend_cnt), 32'd2);
    #2;
    preset = 1'b1;
    #1;
    chk("rst_mid.irq",  32'(bus.irq_out),  32'd0);
    chk("rst_mid.pend", 32'(bus.pend_cnt), 32'd0);
    chk("rst_mid.busy", 32'(bus.busy),     32'd0);
    tick();
    preset = 1'b0;
    run("post_rst_ack", 2, 32'h0, 32'h1, 32'h0, 32'h0);
    run("post_rst_lvl", 6, 32'h1, 32'h10, 32'hE, 32'h1E);
    chk("post_rst.pend0", 32'(bus.pend_cnt), 32'd0);
    chk("post_rst.ovf",   32'(bus.overflow), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_source_gen.md
Name: irq_source_gen

Overview:
- Peripheral-side interrupt signal generator for the PLIC source inputs.
- Converts single-cycle event strobes into well-formed interrupt waveforms: level (held until acknowledged) or pulse (programmable width).
- Queues events in a saturating counter.
- Guarantees a minimum low gap between assertions, so the PLIC edge/level sampler sees one distinct rising edge per event.

Parameters:
- CNT_W, 8, width of pending-event counter (max queued events 2^CNT_W-1)
- PULSE_W, 4, width of pulse_len configuration
- GAP_W, 4, width of gap_len configuration

Ports:
- pclk  input  1  clock
- preset  input  1  asynchronous active-high reset
- en  input  1  generator enable; gates new assertions only
- mode  input  1  0 = level mode, 1 = pulse mode
- pulse_len  input  PULSE_W  pulse-mode high time in cycles (0 treated as 1)
- gap_len  input  GAP_W  enforced low time after each assertion is gap_len+1 cycles
- evt  input  1  event strobe, one event per cycle sampled high
- ack  input  1  completion/acknowledge from the interrupt handler (level mode)
- ovf_clr  input  1  clears sticky overflow
- irq_out  output  1  interrupt line to PLIC source input, registered
- busy  output  1  high whenever the FSM is not in IDLE
- pend_cnt  output  CNT_W  number of queued, not-yet-issued events
- overflow  output  1  sticky: an event was dropped because pend_cnt was at maximum

Behaviour:
- Clocking and reset:
  - One clock, pclk; reset preset is asynchronous and active-high.
  - While preset is high: irq_out=0, busy=0, pend_cnt=0, overflow=0, FSM=IDLE, latched config cleared.
  - Reset mid-assertion drops irq_out and all queued events immediately (asynchronously).
- Event counter:
  - evt high increments pend_cnt at the next edge.
  - FSM issue (IDLE->ASSERT) decrements it.
  - evt and issue in the same cycle leave pend_cnt unchanged.
  - At max, evt without a simultaneous issue is dropped and sets overflow.
  - evt at max with a simultaneous issue is accepted (no overflow).
  - ovf_clr clears overflow; a set condition in the same cycle wins.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: if en=1 and pend_cnt!=0 then go to ASSERT, decrement pend_cnt, latch mode and pulse_len, set irq_out=1 at the same edge.
    - Latency: evt sampled at edge N with pend_cnt=0 and FSM idle gives pend_cnt=1 after N and irq_out=1 after edge N+1.
  - ASSERT, pulse mode: irq_out stays high for exactly max(pulse_len,1) cycles, then clears to 0 and enters GAP. ack is ignored.
  - ASSERT, level mode: irq_out stays high until ack is sampled high. At that edge irq_out clears to 0 and the FSM enters GAP.
  - GAP: irq_out=0 for exactly gap_len+1 cycles, with gap_len latched on entry, then return to IDLE.
    - A queued event may issue on the IDLE cycle that follows, so the minimum low time between assertions is gap_len+2 cycles.
  - ack in IDLE or GAP is ignored and not remembered.
- Configuration changes:
  - Changes to mode, pulse_len or gap_len during ASSERT/GAP take effect on the next issue only.
  - en deasserted during ASSERT/GAP does not truncate the current waveform; it only blocks the next IDLE->ASSERT.
  - Events are still counted while en=0.
- busy is registered and equals (state != IDLE).
- irq_out is driven directly from a flop (glitch-free).

Test Plan:
- Pulse single: mode=1, pulse_len=3, gap_len=2, en=1, one evt -> irq_out high 2 edges after evt for exactly 3 cycles, then low ≥3 cycles; pend_cnt returns to 0; busy high for 6 cycles.
- Pulse burst: 4 consecutive evt strobes, pulse_len=1, gap_len=0 -> pend_cnt peaks at 3; irq_out shows 4 separate 1-cycle pulses, each separated by 2 low cycles; final pend_cnt=0.
- Level/ack: mode=0, one evt, ack asserted 10 cycles after irq_out rises -> irq_out high exactly 10 cycles, low for gap_len+1 cycles; early ack pulse while IDLE has no effect.
- Overflow: CNT_W=2, en=0, 5 evt strobes -> pend_cnt=3, overflow=1; ovf_clr -> overflow=0; en=1 -> 3 pulses issued.
- Simultaneous: evt on the same cycle as an IDLE issue with pend_cnt=1 -> pend_cnt stays 1; ovf_clr together with a dropped evt at max -> overflow stays 1.
- Reset mid-operation: preset asserted during a level assertion with pend_cnt=2 -> irq_out=0, pend_cnt=0, busy=0 immediately; after release, ack and evt behave as from cold reset.
